// File: rtl/picomem_timer.sv
// -----------------------------------------------------------------------------
// picomem_timer
//   32-bit timer/compare peripheral on a PicoMem slave port. A prescaled
//   up-counter is compared against COMPARE. A match sets a sticky MATCH flag
//   and, in periodic mode, reloads the counter to zero. A level interrupt is
//   raised while an enabled flag is set. An optional capture input can latch
//   COUNT into CAPTURE on a rising edge.
//
//   Optional feature macro: PICOMEM_TIMER_CAPTURE_EN
//     defined   : capture_in is synchronised (2 FF) and edge-detected. A rising
//                 edge copies COUNT into CAPTURE and sets STATUS.CAPT.
//     undefined : no capture logic. CAPTURE and STATUS[1] read as 0.
//
//   Ports
//     clk          system clock
//     reset        asynchronous, active-high reset
//     mem_s_valid  request valid, held by the master until mem_s_ready
//     mem_s_ready  one-cycle acknowledge, registered
//     mem_s_addr   byte address; only [4:2] is decoded
//     mem_s_wdata  write data
//     mem_s_wstrb  byte write strobes; all-zero means read
//     mem_s_rdata  read data, valid while mem_s_ready is high, else 0
//     irq          registered level interrupt
//     capture_in   asynchronous capture input (used only with the macro)
//
//   Register map (addr[4:2])
//     0 CTRL      [0] EN, [1] PERIODIC, [2] IRQ_EN
//     1 PRESCALE  [PRESCALE_W-1:0]
//     2 COUNT     current count; a write loads it
//     3 COMPARE   match value
//     4 STATUS    [0] MATCH, [1] CAPT; both sticky and write-1-to-clear
//     5 CAPTURE   read-only captured COUNT
//     6,7         read 0; writes are ignored but still acknowledged
// -----------------------------------------------------------------------------
module picomem_timer #(
  parameter int          PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_s_valid,
  output logic        mem_s_ready,
  input  logic [31:0] mem_s_addr,
  input  logic [31:0] mem_s_wdata,
  input  logic [3:0]  mem_s_wstrb,
  output logic [31:0] mem_s_rdata,
  output logic        irq,
  input  logic        capture_in
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_CAPTURE  = 3'd5;

  // Merge the strobed bytes of new_val over old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  ready_q,    ready_d;
  logic [31:0]           rdata_q,    rdata_d;
  logic                  irq_q,      irq_d;
  logic [2:0]            ctrl_q,     ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [31:0]           count_q,    count_d;
  logic [31:0]           compare_q,  compare_d;
  logic                  match_q,    match_d;

  logic                  req_s;
  logic                  wr_s;
  logic [2:0]            reg_sel_s;
  logic                  tick_s;
  logic                  match_set_s;
  logic [31:0]           rd_val_s;
  logic [31:0]           capture_rd_s;
  logic                  capt_rd_s;

  logic ctrl_en_s;
  logic ctrl_periodic_s;
  logic ctrl_irq_en_s;

  assign ctrl_en_s       = ctrl_q[0];
  assign ctrl_periodic_s = ctrl_q[1];
  assign ctrl_irq_en_s   = ctrl_q[2];

  // A request is accepted in any cycle where ready is low. Because the ack
  // follows one cycle later, ready can never be high two cycles in a row.
  assign req_s     = mem_s_valid & ~ready_q;
  assign wr_s      = req_s & (|mem_s_wstrb);
  assign reg_sel_s = mem_s_addr[4:2];

  // Prescaler: counts 0..PRESCALE while enabled and ticks on the terminal value.
  always_comb begin
    tick_s    = 1'b0;
    pre_cnt_d = pre_cnt_q;
    if (ctrl_en_s) begin
      if (pre_cnt_q == prescale_q) begin
        tick_s    = 1'b1;
        pre_cnt_d = {PRESCALE_W{1'b0}};
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1'b1);
      end
    end else begin
      pre_cnt_d = {PRESCALE_W{1'b0}};
    end
  end

  assign match_set_s = tick_s & (count_q == compare_q);

  // Counter: tick increments or reloads it. A CPU write to COUNT takes priority.
  always_comb begin
    count_d = count_q;
    if (wr_s && (reg_sel_s == REG_COUNT)) begin
      count_d = merge_bytes(count_q, mem_s_wdata, mem_s_wstrb);
    end else if (match_set_s && ctrl_periodic_s) begin
      count_d = 32'h0000_0000;
    end else if (tick_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // CTRL, PRESCALE and COMPARE write paths with per-byte strobes.
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    if (wr_s && (reg_sel_s == REG_CTRL) && mem_s_wstrb[0]) begin
      ctrl_d = mem_s_wdata[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    if (wr_s && (reg_sel_s == REG_PRESCALE)) begin
      for (int b = 0; b < PRESCALE_W; b++) begin
        if (mem_s_wstrb[b/8]) begin
          prescale_d[b] = mem_s_wdata[b];
        end else begin
          prescale_d[b] = prescale_q[b];
        end
      end
    end else begin
      prescale_d = prescale_q;
    end
    if (wr_s && (reg_sel_s == REG_COMPARE)) begin
      compare_d = merge_bytes(compare_q, mem_s_wdata, mem_s_wstrb);
    end else begin
      compare_d = compare_q;
    end
  end

  // MATCH flag: a W1C clears it, and a new match in the same cycle wins.
  always_comb begin
    match_d = match_q;
    if (match_set_s) begin
      match_d = 1'b1;
    end else if (wr_s && (reg_sel_s == REG_STATUS) && mem_s_wstrb[0] && mem_s_wdata[0]) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end
  end

`ifdef PICOMEM_TIMER_CAPTURE_EN
  // Synchroniser stages [0],[1]; stage [2] holds the previous synchronised level.
  logic [2:0]  sync_q,    sync_d;
  logic [31:0] capture_q, capture_d;
  logic        capt_q,    capt_d;
  logic        cap_edge_s;
  logic        unused_s;

  assign unused_s   = ^{mem_s_addr[31:5], mem_s_addr[1:0]};
  assign cap_edge_s = sync_q[1] & ~sync_q[2];

  // Capture path: synchronise, detect the rising edge, latch COUNT and set CAPT.
  always_comb begin
    sync_d    = {sync_q[1:0], capture_in};
    capture_d = capture_q;
    capt_d    = capt_q;
    if (cap_edge_s) begin
      capture_d = count_q;
    end else begin
      capture_d = capture_q;
    end
    if (cap_edge_s) begin
      capt_d = 1'b1;
    end else if (wr_s && (reg_sel_s == REG_STATUS) && mem_s_wstrb[0] && mem_s_wdata[1]) begin
      capt_d = 1'b0;
    end else begin
      capt_d = capt_q;
    end
  end

  // Capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 3'b000;
      capture_q <= 32'h0000_0000;
      capt_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      capture_q <= capture_d;
      capt_q    <= capt_d;
    end
  end

  assign capture_rd_s = capture_q;
  assign capt_rd_s    = capt_q;
`else
  logic unused_s;

  assign unused_s     = ^{capture_in, mem_s_addr[31:5], mem_s_addr[1:0]};
  assign capture_rd_s = 32'h0000_0000;
  assign capt_rd_s    = 1'b0;
`endif

  // Read mux; the value is sampled in the request cycle.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (reg_sel_s)
      REG_CTRL:     rd_val_s = {29'h0000_0000, ctrl_q};
      REG_PRESCALE: rd_val_s = 32'(prescale_q);
      REG_COUNT:    rd_val_s = count_q;
      REG_COMPARE:  rd_val_s = compare_q;
      REG_STATUS:   rd_val_s = {30'h0000_0000, capt_rd_s, match_q};
      REG_CAPTURE:  rd_val_s = capture_rd_s;
      default:      rd_val_s = 32'h0000_0000;
    endcase
  end

  // Bus response and interrupt next-state.
  always_comb begin
    ready_d = req_s;
    if (req_s) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end
    irq_d = (match_q | capt_rd_s) & ctrl_irq_en_s;
  end

  // Core registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      irq_q      <= 1'b0;
      ctrl_q     <= 3'b000;
      prescale_q <= {PRESCALE_W{1'b0}};
      pre_cnt_q  <= {PRESCALE_W{1'b0}};
      count_q    <= 32'h0000_0000;
      compare_q  <= RESET_COMPARE;
      match_q    <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
    end
  end

  assign mem_s_ready = ready_q;
  assign mem_s_rdata = rdata_q;
  assign irq         = irq_q;

endmodule
